// File: rtl/spi_parallel_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_parallel_master_ctrl
// Description : Master-side sequencer for the parallel-lane SPI link
//               (CPOL=0, CPHA=0, one full NB_BITS word per SCLK period).
//               Runs bursts of 1..2^NB_LEN-1 words, drives CS/SCLK/MOSI,
//               captures MISO, and handshakes words with the host logic.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_parallel_master_ctrl #(
  parameter int NB_BITS      = 32,
  parameter int NB_LEN       = 8,
  parameter int HALF_PERIOD  = 4,
  parameter int SETUP_CYCLES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [NB_LEN-1:0]  i_len,
  input  logic [NB_BITS-1:0] i_tx_data,
  input  logic               i_abort,
  input  logic [NB_BITS-1:0] i_MISO,
  output logic [NB_BITS-1:0] o_MOSI,
  output logic               o_SCLK,
  output logic               o_cs,
  output logic               o_tx_next,
  output logic [NB_BITS-1:0] o_rx_data,
  output logic               o_rx_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_aborted
);

  // Phase counter must hold the longer of the two phase durations.
  localparam int c_MAX_DUR = (HALF_PERIOD > SETUP_CYCLES) ? HALF_PERIOD : SETUP_CYCLES;
  localparam int c_CNT_W   = $clog2(c_MAX_DUR) + 1;

  localparam logic [c_CNT_W-1:0] c_SETUP_LAST = c_CNT_W'(SETUP_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_HALF_LAST  = c_CNT_W'(HALF_PERIOD - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_ZERO   = '0;
  localparam logic [NB_LEN-1:0]  c_ONE_WORD   = NB_LEN'(1);
  localparam logic [NB_LEN-1:0]  c_NO_WORDS   = '0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_GAP   = 3'd4,
    ST_HOLD  = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic [NB_LEN-1:0]    r_words_left;
  logic [NB_LEN-1:0]    w_words_nxt;
  logic                 r_abt;
  logic                 w_abt_nxt;
  logic [NB_BITS-1:0]   r_mosi;
  logic [NB_BITS-1:0]   w_mosi_nxt;
  logic [NB_BITS-1:0]   r_rx_data;
  logic [NB_BITS-1:0]   w_rx_data_nxt;
  logic                 r_rx_valid;
  logic                 w_rx_valid_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 r_aborted;
  logic                 w_aborted_nxt;
  logic                 r_tx_next;
  logic                 w_tx_next_nxt;
  logic                 r_cs;
  logic                 r_sclk;
  logic                 r_busy;
  logic                 w_cnt_last;
  logic                 w_abort_ok;

  assign w_cnt_last = (r_cnt == c_CNT_ZERO);

  // State, counters, datapath and all outputs are registered here.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= c_CNT_ZERO;
      r_words_left <= c_NO_WORDS;
      r_abt        <= 1'b0;
      r_mosi       <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_tx_next    <= 1'b0;
      r_cs         <= 1'b0;
      r_sclk       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_words_left <= w_words_nxt;
      r_abt        <= w_abt_nxt;
      r_mosi       <= w_mosi_nxt;
      r_rx_data    <= w_rx_data_nxt;
      r_rx_valid   <= w_rx_valid_nxt;
      r_done       <= w_done_nxt;
      r_aborted    <= w_aborted_nxt;
      r_tx_next    <= w_tx_next_nxt;
      r_cs         <= (w_state_nxt != ST_IDLE);
      r_sclk       <= (w_state_nxt == ST_HIGH);
      r_busy       <= (w_state_nxt != ST_IDLE);
    end
  end

  // Next-state, phase timing, word bookkeeping and next output values.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_words_nxt    = r_words_left;
    w_abt_nxt      = r_abt;
    w_mosi_nxt     = r_mosi;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_done_nxt     = 1'b0;
    w_aborted_nxt  = 1'b0;
    w_tx_next_nxt  = 1'b0;
    // Abort is honoured only while the link is actively sequencing.
    w_abort_ok     = i_abort;

    case (r_state)
      ST_IDLE: begin
        if (i_start && (i_len != c_NO_WORDS)) begin
          w_state_nxt = ST_SETUP;
          w_cnt_nxt   = c_SETUP_LAST;
          w_words_nxt = i_len;
          w_mosi_nxt  = i_tx_data;
          w_abt_nxt   = 1'b0;
        end
      end

      ST_SETUP, ST_GAP: begin
        if (w_abort_ok) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = c_SETUP_LAST;
          w_abt_nxt   = 1'b1;
        end else if (w_cnt_last) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = c_HALF_LAST;
        end else begin
          w_cnt_nxt   = r_cnt - c_CNT_ONE;
        end
      end

      ST_HIGH: begin
        if (w_abort_ok) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = c_SETUP_LAST;
          w_abt_nxt   = 1'b1;
        end else if (w_cnt_last) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = c_HALF_LAST;
        end else begin
          w_cnt_nxt   = r_cnt - c_CNT_ONE;
        end
      end

      ST_LOW: begin
        if (w_abort_ok) begin
          // Abort beats the end-of-word capture and the next-word fetch.
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = c_SETUP_LAST;
          w_abt_nxt   = 1'b1;
        end else if (w_cnt_last) begin
          w_rx_data_nxt  = i_MISO;
          w_rx_valid_nxt = 1'b1;
          w_words_nxt    = r_words_left - c_ONE_WORD;
          w_cnt_nxt      = c_SETUP_LAST;
          if (r_words_left > c_ONE_WORD) begin
            w_mosi_nxt  = i_tx_data;
            w_state_nxt = ST_GAP;
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
      end

      ST_HOLD: begin
        if (w_cnt_last) begin
          w_state_nxt   = ST_IDLE;
          w_cnt_nxt     = c_CNT_ZERO;
          w_done_nxt    = 1'b1;
          w_aborted_nxt = r_abt;
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = c_CNT_ZERO;
      end
    endcase

    // Request the next word during the final LOW cycle of a non-final word;
    // HALF_PERIOD >= 2 guarantees this is only reached by counting down in LOW.
    w_tx_next_nxt = (w_state_nxt == ST_LOW) && (w_cnt_nxt == c_CNT_ZERO) &&
                    (r_words_left > c_ONE_WORD);
  end

  assign o_MOSI     = r_mosi;
  assign o_SCLK     = r_sclk;
  assign o_cs       = r_cs;
  assign o_tx_next  = r_tx_next;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_aborted  = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_spi_parallel_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_parallel_master_ctrl
// Description : Self-checking bench for spi_parallel_master_ctrl. Expected
//               waveforms are derived per cycle from burst timing arithmetic
//               (word k occupies a fixed slot after the start edge).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_parallel_master_ctrl;

  localparam int NB_BITS = 32;
  localparam int NB_LEN  = 8;
  localparam int HP      = 4;
  localparam int SC      = 2;

  logic               clk = 1'b0;
  logic               i_rst;
  logic               i_start;
  logic [NB_LEN-1:0]  i_len;
  logic [NB_BITS-1:0] i_tx_data;
  logic               i_abort;
  logic [NB_BITS-1:0] i_MISO;
  logic [NB_BITS-1:0] o_MOSI;
  logic               o_SCLK;
  logic               o_cs;
  logic               o_tx_next;
  logic [NB_BITS-1:0] o_rx_data;
  logic               o_rx_valid;
  logic               o_busy;
  logic               o_done;
  logic               o_aborted;

  int n_checks = 0;
  int n_errors = 0;

  logic [NB_BITS-1:0] words [0:255];
  logic [NB_BITS-1:0] m_mosi;
  logic [NB_BITS-1:0] m_rx;
  bit                 fixed_miso;
  logic [NB_BITS-1:0] miso_val;

  always #5 clk = ~clk;

  spi_parallel_master_ctrl #(
    .NB_BITS      (NB_BITS),
    .NB_LEN       (NB_LEN),
    .HALF_PERIOD  (HP),
    .SETUP_CYCLES (SC)
  ) u_dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_len      (i_len),
    .i_tx_data  (i_tx_data),
    .i_abort    (i_abort),
    .i_MISO     (i_MISO),
    .o_MOSI     (o_MOSI),
    .o_SCLK     (o_SCLK),
    .o_cs       (o_cs),
    .o_tx_next  (o_tx_next),
    .o_rx_data  (o_rx_data),
    .o_rx_valid (o_rx_valid),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_aborted  (o_aborted)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // First SCLK-high cycle of word k, counted from the start edge.
  function automatic int hi_start(input int k);
    return 1 + SC + k * (2 * HP + SC);
  endfunction

  // Final LOW cycle of word k (capture happens at the edge ending it).
  function automatic int last_low(input int k);
    return hi_start(k) + 2 * HP - 1;
  endfunction

  function automatic logic [6:0] ctl_now();
    return {o_cs, o_SCLK, o_busy, o_done, o_aborted, o_tx_next, o_rx_valid};
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic drive_idle_noise();
    i_start   = 1'b0;
    i_len     = NB_LEN'($urandom);
    i_abort   = 1'($urandom % 2);
    i_tx_data = $urandom;
    i_MISO    = $urandom;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      chk($sformatf("%s ctl", tag), 64'(ctl_now()), 64'(7'b0));
      chk($sformatf("%s mosi", tag), 64'(o_MOSI), 64'(m_mosi));
      chk($sformatf("%s rx", tag), 64'(o_rx_data), 64'(m_rx));
      drive_idle_noise();
    end
  endtask

  // Runs one burst of len words (words[] prefilled); ab = abort cycle or 0.
  // Called in the cycle that presents i_start (cycle 0).
  task automatic run_burst(input int len, input int ab, input bit b2b, input string tag);
    int d;
    int lim;
    int next_word;
    logic [6:0] exp_ctl;
    logic [6:0] mask;
    logic [NB_BITS-1:0] miso_prev;
    bit e_sclk, e_tx, e_rxv, ok;

    lim = (ab == 0) ? last_low(len - 1) : ab;
    d   = (ab == 0) ? last_low(len - 1) + SC + 1 : ab + SC + 1;
    next_word = 1;

    i_start   = 1'b1;
    i_len     = NB_LEN'(len);
    i_tx_data = words[0];
    i_abort   = 1'($urandom % 2);
    i_MISO    = fixed_miso ? miso_val : $urandom;
    miso_prev = i_MISO;
    m_mosi    = words[0];

    for (int c = 1; c <= d; c++) begin
      @(posedge clk); #1;
      e_sclk = 1'b0;
      e_tx   = 1'b0;
      e_rxv  = 1'b0;
      for (int k = 0; k < len; k++) begin
        ok = (ab == 0) || (last_low(k) < ab);
        if (c >= hi_start(k) && c < hi_start(k) + HP && (ab == 0 || c <= ab))
          e_sclk = 1'b1;
        if (k < len - 1 && c == last_low(k) && (ab == 0 || c < ab))
          e_tx = 1'b1;
        if (c - 1 == last_low(k) && ok) begin
          e_rxv = 1'b1;
          m_rx  = miso_prev;
          if (k < len - 1) m_mosi = words[k + 1];
        end
      end
      exp_ctl = {(c < d), e_sclk, (c < d), (c == d), ((c == d) && (ab != 0)), e_tx, e_rxv};
      // A next-word request issued in the very cycle abort arrives is moot.
      mask = (ab != 0 && c == ab) ? 7'b1111101 : 7'b1111111;
      chk($sformatf("%s ctl c=%0d", tag, c), 64'(ctl_now() & mask), 64'(exp_ctl & mask));
      chk($sformatf("%s mosi c=%0d", tag, c), 64'(o_MOSI), 64'(m_mosi));
      chk($sformatf("%s rx c=%0d", tag, c), 64'(o_rx_data), 64'(m_rx));

      if (c < d) begin
        i_start = 1'($urandom % 2);
        i_len   = NB_LEN'($urandom);
        if (c == ab)       i_abort = 1'b1;
        else if (c > lim)  i_abort = 1'($urandom % 2);
        else               i_abort = 1'b0;
        if (o_tx_next && next_word < len) begin
          i_tx_data = words[next_word];
          next_word++;
        end else begin
          i_tx_data = $urandom;
        end
        i_MISO    = fixed_miso ? miso_val : $urandom;
        miso_prev = i_MISO;
      end else if (!b2b) begin
        drive_idle_noise();
      end
    end
    if (!b2b) idle_cycles(2, {tag, " idle"});
  endtask

  initial begin
    int len, ab;
    bit b2b;

    i_rst = 1'b1;
    i_start = 1'b0;
    i_len = '0;
    i_tx_data = '0;
    i_abort = 1'b0;
    i_MISO = '0;
    fixed_miso = 1'b0;
    miso_val = '0;
    m_mosi = '0;
    m_rx = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ctl", 64'(ctl_now()), 64'(7'b0));
    chk("reset mosi", 64'(o_MOSI), 64'(0));
    chk("reset rx", 64'(o_rx_data), 64'(0));
    i_rst = 1'b0;

    // Single word with fixed data.
    fixed_miso = 1'b1;
    miso_val = 32'h1234_5678;
    words[0] = 32'hA5A5_0001;
    run_burst(1, 0, 1'b0, "single");
    fixed_miso = 1'b0;

    // Three-word burst with known words.
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    run_burst(3, 0, 1'b0, "three");

    // Zero length request is ignored.
    i_start = 1'b1; i_len = '0; i_tx_data = $urandom; i_abort = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      chk("len0 ctl", 64'(ctl_now()), 64'(7'b0));
      chk("len0 mosi", 64'(o_MOSI), 64'(m_mosi));
      i_tx_data = $urandom;
    end
    i_start = 1'b0;

    // Abort during the second HIGH phase.
    for (int k = 0; k < 3; k++) words[k] = $urandom;
    run_burst(3, hi_start(1) + 1, 1'b0, "abort_high");

    // Abort coinciding with the last LOW cycle of the first word.
    for (int k = 0; k < 2; k++) words[k] = $urandom;
    run_burst(2, last_low(0), 1'b0, "abort_lastlow");

    // Reset in the LOW phase of a two-word burst.
    words[0] = $urandom; words[1] = $urandom;
    i_start = 1'b1; i_len = NB_LEN'(2); i_tx_data = words[0]; i_abort = 1'b0;
    for (int c = 1; c <= hi_start(0) + HP + 1; c++) begin
      @(posedge clk); #1;
      i_start = 1'b0;
    end
    i_rst = 1'b1;
    i_start = 1'b1;
    i_len = NB_LEN'(3);
    @(posedge clk); #1;
    chk("midrst ctl", 64'(ctl_now()), 64'(7'b0));
    chk("midrst mosi", 64'(o_MOSI), 64'(0));
    chk("midrst rx", 64'(o_rx_data), 64'(0));
    i_rst = 1'b0;
    i_start = 1'b0;
    m_mosi = '0;
    m_rx = '0;
    for (int k = 0; k < 2; k++) words[k] = $urandom;
    run_burst(2, 0, 1'b0, "after_rst");

    // Back-to-back bursts started in the done cycle.
    words[0] = $urandom;
    run_burst(1, 0, 1'b1, "b2b_a");
    for (int k = 0; k < 2; k++) words[k] = $urandom;
    run_burst(2, 0, 1'b0, "b2b_b");

    // Randomized bursts, aborts and back-to-back chaining.
    for (int i = 0; i < 30; i++) begin
      len = $urandom_range(1, 5);
      ab  = ($urandom % 2 == 0) ? 0 : $urandom_range(1, last_low(len - 1));
      b2b = (i < 29) && ($urandom % 3 == 0);
      for (int k = 0; k < len; k++) words[k] = $urandom;
      run_burst(len, ab, b2b, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_parallel_master_ctrl.md
Name: spi_parallel_master_ctrl

Overview:
- Master-side transfer sequencer for the parallel-lane SPI link (CPOL=0, CPHA=0, NB_BITS lanes per SCLK edge).
- Generates o_cs and o_SCLK, and drives full-word o_MOSI; captures full-word i_MISO.
- Runs bursts of 1..2^NB_LEN-1 words under a start/next/valid/done handshake with the host logic (debug unit / MIPS control side).
- SCLK phases are stretched to HALF_PERIOD system clocks so a slave that edge-detects SCLK with i_clk sees every edge.

Parameters:
NB_BITS, 32, word width of o_MOSI / i_MISO / data ports
NB_LEN, 8, width of burst-length input
HALF_PERIOD, 4, i_clk cycles per SCLK high or low phase (legal >= 2)
SETUP_CYCLES, 2, i_clk cycles for CS setup, inter-word gap and CS hold (legal >= 1)

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst  input  1  synchronous reset, active-high
i_start  input  1  request burst; sampled only in IDLE
i_len  input  NB_LEN  words in burst; latched with i_start; 0 = request ignored
i_tx_data  input  NB_BITS  word to send; sampled at start and in cycles where o_tx_next=1
i_abort  input  1  terminate burst early
i_MISO  input  NB_BITS  slave return word
o_MOSI  output  NB_BITS  word driven to slave
o_SCLK  output  1  SPI clock, idles 0
o_cs  output  1  chip select, active-high
o_tx_next  output  1  1-cycle pulse: present next i_tx_data this cycle
o_rx_data  output  NB_BITS  last captured i_MISO word
o_rx_valid  output  1  1-cycle pulse: o_rx_data updated
o_busy  output  1  burst in progress (not IDLE)
o_done  output  1  1-cycle pulse at end of burst
o_aborted  output  1  valid with o_done: burst ended by i_abort

Behaviour:
- Outputs are registered. Reset (any state, mid-burst included) forces: state IDLE, o_cs=0, o_SCLK=0, o_MOSI=0, o_rx_data=0, all pulses=0, o_busy=0, counters=0. Reset wins over every other input.
- States: IDLE, SETUP, HIGH, LOW, GAP, HOLD.
- IDLE: if i_start=1 and i_len!=0 at edge n, latch i_len into words_left and i_tx_data into o_MOSI. From cycle n+1: SETUP, o_cs=1, o_busy=1.
- SETUP (SETUP_CYCLES cycles, SCLK=0) -> HIGH.
- HIGH (HALF_PERIOD cycles, o_SCLK=1) -> LOW.
- LOW (HALF_PERIOD cycles, o_SCLK=0).
  - During the last LOW cycle, o_tx_next=1 if words_left>1.
  - At the edge ending that cycle:
    - i_MISO -> o_rx_data; o_rx_valid=1 in the next cycle.
    - words_left decrements.
    - If more words remain, i_tx_data -> o_MOSI and go to GAP; otherwise go to HOLD.
- GAP (SETUP_CYCLES, o_cs stays 1, SCLK=0) -> HIGH.
- HOLD (SETUP_CYCLES, o_cs=1, SCLK=0). Next cycle: IDLE, o_cs=0, o_done=1, o_busy=0.
- A start in that done cycle is accepted (back-to-back bursts).
- Single-word latency, start edge to o_done: 2*SETUP_CYCLES + 2*HALF_PERIOD + 1 cycles.
- i_abort=1 in SETUP/HIGH/LOW/GAP: next cycle HOLD, o_SCLK=0.
  - No o_rx_valid for the interrupted word; no o_tx_next.
  - o_aborted=1 together with o_done.
  - i_abort is ignored in IDLE and HOLD.
- Simultaneous i_abort and last LOW cycle: abort wins; no capture, no o_tx_next response is taken.
- i_start outside IDLE is ignored. o_MOSI holds its last value after the burst. o_rx_data holds until the next capture.
- Counters: phase counter clog2(max(HALF_PERIOD,SETUP_CYCLES))+1 bits; words_left NB_LEN bits, no wrap.

Test Plan:
1. Reset, then i_start with i_len=1, i_tx_data=0xA5A5_0001 at edge 0, i_MISO=0x1234_5678 (defaults) -> o_cs=1 in cycles 1-12; o_SCLK=1 in cycles 3-6; o_rx_valid=1 in cycle 11 with o_rx_data=0x1234_5678; o_done=1, o_cs=0 in cycle 13; o_tx_next never asserted.
2. i_len=3, words 0x11/0x22/0x33 supplied on o_tx_next -> exactly 2 o_tx_next pulses and 3 o_rx_valid pulses; o_MOSI sequence 0x11, 0x22, 0x33; 3 SCLK high pulses of 4 cycles; o_cs continuous; o_aborted=0.
3. i_len=0 with i_start=1 -> stays IDLE: o_busy=0, o_cs=0, no o_done.
4. i_len=3, i_abort during the second HIGH phase -> o_SCLK=0 next cycle; one o_rx_valid total; o_done with o_aborted=1 two cycles after HOLD entry; o_cs drops with o_done.
5. i_rst during the LOW phase of a 2-word burst -> next cycle all outputs are at reset values; a following i_start runs a normal burst.
6. i_start held high in the o_done cycle -> new burst begins: o_cs=1 on the next cycle; i_start pulses while busy are ignored.
